// File: rtl/instruction_queue.sv
// rtl/instruction_queue.sv - decode-to-dispatch instruction FIFO, first-word-fall-through with flush
// Optional macro IQ_BYPASS_EN: empty-queue push is presented on pop_data in the same cycle.

package instruction_queue_pkg;
    typedef struct packed {
        logic        valid;
        logic [31:0] pc_curr;
        logic [31:0] instr;
        logic [4:0]  rd;
    } instruction_info_reg_t;
endpackage

module instruction_queue
    import instruction_queue_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      flush,
    input  logic                      push,
    input  instruction_info_reg_t     push_data,
    output logic                      full,
    input  logic                      pop,
    output instruction_info_reg_t     pop_data,
    output logic                      empty,
    output logic [$clog2(DEPTH):0]    count
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    instruction_info_reg_t mem [DEPTH];

    logic [PW-1:0] head_q, tail_q, count_q;
    logic [PW-1:0] head_n, tail_n, count_n;
    logic          full_q, empty_q, full_n, empty_n;
    logic          bypass_live, bypass_take;
    logic          push_acc, pop_acc;

`ifdef IQ_BYPASS_EN
    assign bypass_live = empty_q && push && !flush;
`else
    assign bypass_live = 1'b0;
`endif
    // A bypassed pop consumes the incoming entry, so it must not also be written.
    assign bypass_take = bypass_live && pop;
    assign push_acc    = push && !full_q && !flush && !bypass_take;
    assign pop_acc     = pop && !empty_q && !flush;

    always_comb begin
        head_n  = head_q;
        tail_n  = tail_q;
        count_n = count_q;
        if (flush) begin
            head_n  = '0;
            tail_n  = '0;
            count_n = '0;
        end else begin
            if (push_acc)
                tail_n = tail_q + PW'(1);
            if (pop_acc)
                head_n = head_q + PW'(1);
            if (push_acc && !pop_acc)
                count_n = count_q + PW'(1);
            else if (pop_acc && !push_acc)
                count_n = count_q - PW'(1);
        end
        empty_n = (head_n == tail_n);
        full_n  = (head_n[AW-1:0] == tail_n[AW-1:0]) && (head_n[AW] != tail_n[AW]);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
        end else begin
            head_q  <= head_n;
            tail_q  <= tail_n;
            count_q <= count_n;
            full_q  <= full_n;
            empty_q <= empty_n;
        end
    end

    // Contents need no reset: the read side is gated by empty.
    always_ff @(posedge clk) begin
        if (!rst && push_acc)
            mem[tail_q[AW-1:0]] <= push_data;
    end

    always_comb begin
        pop_data = '0;
        if (bypass_live)
            pop_data = push_data;
        else if (!empty_q)
            pop_data = mem[head_q[AW-1:0]];
    end

    assign full  = full_q;
    assign empty = empty_q;
    assign count = count_q;

endmodule

// File: tb/tb_instruction_queue.sv
// tb/tb_instruction_queue.sv - scoreboard bench for instruction_queue (DEPTH 16)
module tb_instruction_queue;
    import instruction_queue_pkg::*;

    localparam int DEPTH = 16;
`ifdef IQ_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic                  flush = 1'b0;
    logic                  push = 1'b0;
    logic                  pop = 1'b0;
    instruction_info_reg_t push_data = '0;
    instruction_info_reg_t pop_data;
    logic                  full, empty;
    logic [4:0]            count;

    int          checks = 0;
    int          errors = 0;
    int          mcount = 0;
    logic [31:0] exp_q[$];
    bit          mon_pop = 1'b0;

    instruction_queue #(.DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .push      (push),
        .push_data (push_data),
        .full      (full),
        .pop       (pop),
        .pop_data  (pop_data),
        .empty     (empty),
        .count     (count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %h want %h", name, got, want);
        end
    endtask

    // Monitor: compares status against the occupancy model and pops the scoreboard on every accepted pop.
    always @(negedge clk) begin
        if (!rst) begin
            chk("count", 32'(count), 32'(mcount));
            chk("empty", 32'(empty), 32'(mcount == 0));
            chk("full", 32'(full), 32'(mcount == DEPTH));
            if (mon_pop) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL pop_underflow got pc %h want no pop", pop_data.pc_curr);
                end else begin
                    logic [31:0] w;
                    w = exp_q.pop_front();
                    chk("pop_valid", 32'(pop_data.valid), 32'd1);
                    chk("pop_pc", pop_data.pc_curr, w);
                end
            end else if (mcount == 0 && !(BYP && push && !flush)) begin
                chk("idle_valid", 32'(pop_data.valid), 32'd0);
            end
        end
    end

    task automatic cyc(input bit p, input logic [31:0] pc, input bit q, input bit f);
        bit pacc, qacc, byp;
        push = p;
        pop = q;
        flush = f;
        push_data.valid   = 1'b1;
        push_data.pc_curr = pc;
        push_data.instr   = pc ^ 32'hffff0000;
        push_data.rd      = pc[6:2];
        byp  = BYP && mcount == 0 && p && q && !f;
        pacc = p && !f && mcount < DEPTH && !byp;
        qacc = q && !f && mcount > 0;
        mon_pop = qacc || byp;
        if (byp)
            exp_q.push_back(pc);
        @(posedge clk);
        #1;
        mon_pop = 1'b0;
        if (f) begin
            exp_q.delete();
            mcount = 0;
        end else begin
            mcount = mcount + (pacc ? 1 : 0) - (qacc ? 1 : 0);
        end
        if (pacc)
            exp_q.push_back(pc);
        push = 1'b0;
        pop = 1'b0;
        flush = 1'b0;
    endtask

    initial begin
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_full", 32'(full), 32'd0);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_valid", 32'(pop_data.valid), 32'd0);

        for (int i = 0; i < 16; i++)
            cyc(1'b1, 32'h1000 + 32'(4 * i), 1'b0, 1'b0);
        chk("fill_full", 32'(full), 32'd1);
        chk("fill_count", 32'(count), 32'd16);
        cyc(1'b1, 32'hdead0000, 1'b0, 1'b0);
        chk("drop_count", 32'(count), 32'd16);

        // Push while full is dropped even alongside a pop.
        cyc(1'b1, 32'hdead0001, 1'b1, 1'b0);
        chk("full_pushpop_count", 32'(count), 32'd15);
        for (int i = 0; i < 7; i++)
            cyc(1'b0, 32'h0, 1'b1, 1'b0);
        for (int i = 0; i < 8; i++)
            cyc(1'b1, 32'h1040 + 32'(4 * i), 1'b1, 1'b0);
        chk("steady_count", 32'(count), 32'd8);
        for (int i = 0; i < 16; i++)
            cyc(1'b0, 32'h0, 1'b1, 1'b0);
        chk("drain_empty", 32'(empty), 32'd1);

        for (int i = 0; i < 5; i++)
            cyc(1'b1, 32'h3000 + 32'(4 * i), 1'b0, 1'b0);
        cyc(1'b1, 32'h3014, 1'b1, 1'b0);
        chk("pp5_count", 32'(count), 32'd5);
        chk("pp5_head", pop_data.pc_curr, 32'h3004);

        for (int i = 0; i < 2; i++)
            cyc(1'b1, 32'h3018 + 32'(4 * i), 1'b0, 1'b0);
        chk("pre_flush_count", 32'(count), 32'd7);
        cyc(1'b1, 32'h4444, 1'b1, 1'b1);
        chk("flush_empty", 32'(empty), 32'd1);
        chk("flush_count", 32'(count), 32'd0);
        chk("flush_valid", 32'(pop_data.valid), 32'd0);
        cyc(1'b1, 32'h5000, 1'b0, 1'b0);
        chk("post_flush_valid", 32'(pop_data.valid), 32'd1);
        chk("post_flush_pc", pop_data.pc_curr, 32'h5000);
        cyc(1'b0, 32'h0, 1'b1, 1'b0);

        cyc(1'b1, 32'h2000, 1'b1, 1'b0);
        chk("bypass_count", 32'(count), BYP ? 32'd0 : 32'd1);
        if (!BYP)
            cyc(1'b0, 32'h0, 1'b1, 1'b0);
        cyc(1'b0, 32'h0, 1'b0, 1'b0);
        chk("end_empty", 32'(empty), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
